pixel_row_reader: RTL

Frame readout controller on the consumer side of the pixel rows. It selects one row at a time by asserting that row's read strobe. It waits for the shared row data bus to settle, then captures the whole row into a local buffer. It then serialises the captured pixels, one per beat, onto a valid/ready stream toward the frame output logic. It sits between the pixel array and the downstream pixel consumer, and it alone drives every row's read enable.

---
 rtl/pixel_row_reader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pixel_row_reader.sv
// ---------------------------------------------------------------------------
// pixel_row_reader
//
// Consumer-side frame readout controller for a pixel array. On START it walks
// the rows in order. For each row it:
//   - raises that row's read strobe,
//   - waits SETTLE_CYCLES for the shared row bus to settle,
//   - captures the whole row into a local buffer,
//   - streams the buffered pixels one per beat on a valid/ready interface.
// After the last beat of the last row it pulses DONE for one cycle.
//
// Ports:
//   CLK        rising-edge clock
//   RESET      asynchronous active-low reset
//   START      one-cycle frame request (ignored unless idle)
//   ROW_READ   one-hot row read strobes (bit r selects row r)
//   ROW_DATA   shared row bus, column i at bits [i*PIXEL_BITS +: PIXEL_BITS]
//   OUT_DATA   current pixel
//   OUT_VALID  beat valid
//   OUT_READY  consumer accepts the beat
//   OUT_ROW    row index of the current beat
//   OUT_COL    column index of the current beat
//   OUT_LAST   final pixel of the frame
//   BUSY       frame readout in progress (includes the DONE cycle)
//   DONE       one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
module pixel_row_reader #(
    parameter int ARRAY_WIDTH   = 2,
    parameter int ARRAY_HEIGHT  = 2,
    parameter int PIXEL_BITS    = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                                                     CLK,
    input  logic                                                     RESET,
    input  logic                                                     START,
    output logic [ARRAY_HEIGHT-1:0]                                  ROW_READ,
    input  logic [ARRAY_WIDTH*PIXEL_BITS-1:0]                        ROW_DATA,
    output logic [PIXEL_BITS-1:0]                                    OUT_DATA,
    output logic                                                     OUT_VALID,
    input  logic                                                     OUT_READY,
    output logic [(ARRAY_HEIGHT > 1 ? $clog2(ARRAY_HEIGHT) : 1)-1:0] OUT_ROW,
    output logic [(ARRAY_WIDTH > 1 ? $clog2(ARRAY_WIDTH) : 1)-1:0]   OUT_COL,
    output logic                                                     OUT_LAST,
    output logic                                                     BUSY,
    output logic                                                     DONE
);

    localparam int ROW_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int COL_W = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
    // Counter must be able to hold SETTLE_CYCLES itself: it still increments
    // on the capture edge.
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ARRAY_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ARRAY_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("pixel_row_reader: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                  state;
    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        col;
    logic [CNT_W-1:0]        settle_cnt;
    logic [PIXEL_BITS-1:0]   row_buf [ARRAY_WIDTH];

    logic [ROW_W-1:0]        row_nxt;
    logic [COL_W-1:0]        col_nxt;

    assign row_nxt = row + 1'b1;
    assign col_nxt = col + 1'b1;

    function automatic logic [ARRAY_HEIGHT-1:0] row_strobe(input logic [ROW_W-1:0] idx);
        row_strobe = '0;
        for (int r = 0; r < ARRAY_HEIGHT; r++) begin
            if (idx == ROW_W'(r)) row_strobe[r] = 1'b1;
        end
    endfunction

    // All outputs are registered and updated together with the state, so
    // each output value reflects the state being entered.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            settle_cnt <= '0;
            for (int i = 0; i < ARRAY_WIDTH; i++) row_buf[i] <= '0;
            ROW_READ   <= '0;
            OUT_DATA   <= '0;
            OUT_VALID  <= 1'b0;
            OUT_ROW    <= '0;
            OUT_COL    <= '0;
            OUT_LAST   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state      <= SETTLE;
                        row        <= '0;
                        settle_cnt <= '0;
                        ROW_READ   <= row_strobe('0);
                        BUSY       <= 1'b1;
                    end
                end

                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == CNT_LAST) begin
                        // Capture edge: the bus has been driven long enough.
                        for (int i = 0; i < ARRAY_WIDTH; i++) begin
                            row_buf[i] <= ROW_DATA[i*PIXEL_BITS +: PIXEL_BITS];
                        end
                        col       <= '0;
                        state     <= STREAM;
                        ROW_READ  <= '0;
                        OUT_VALID <= 1'b1;
                        // First beat comes straight from the bus being captured.
                        OUT_DATA  <= ROW_DATA[PIXEL_BITS-1:0];
                        OUT_ROW   <= row;
                        OUT_COL   <= '0;
                        OUT_LAST  <= (row == ROW_LAST) && (ARRAY_WIDTH == 1);
                    end
                end

                STREAM: begin
                    if (OUT_READY) begin
                        if (col != COL_LAST) begin
                            col      <= col_nxt;
                            OUT_COL  <= col_nxt;
                            OUT_DATA <= row_buf[col_nxt];
                            OUT_LAST <= (row == ROW_LAST) && (col_nxt == COL_LAST);
                        end else begin
                            OUT_VALID <= 1'b0;
                            OUT_DATA  <= '0;
                            OUT_ROW   <= '0;
                            OUT_COL   <= '0;
                            OUT_LAST  <= 1'b0;
                            if (row != ROW_LAST) begin
                                row        <= row_nxt;
                                settle_cnt <= '0;
                                state      <= SETTLE;
                                ROW_READ   <= row_strobe(row_nxt);
                            end else begin
                                state <= FINISH;
                                DONE  <= 1'b1;
                            end
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
